sd_init_sequencer: RTL and testbench
====================================

Name: sd_init_sequencer

Overview:
Sequences the SD-card identification flow over the SDIO command engine: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3. It owns the engine's request port during init, captures OCR/RCA, and reports done or a coded error. It sits between top-level control (UART debug/start logic) and the CMD-line shifter, which does the serialisation, CRC7 and response capture.

Parameters:
POWERUP_WAIT, 27000, clk cycles idled after start before CMD0 (1 ms at 27 MHz)
ACMD41_RETRIES, 1000, max ACMD41 attempts before error (10-bit counter, must be >= 1)
HCS, 1, host-capacity-support bit placed in the ACMD41 argument for v2 cards

Ports:
clk  in  1  system clock (27 MHz)
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins sequence when idle/done/error
busy  out  1  high from accepted start until done or error
done  out  1  level; card identified, RCA valid
error  out  1  level; sequence aborted
err_code  out  4  reason, valid while error=1
cmd_valid  out  1  command request to engine
cmd_ready  in  1  engine accepts command
cmd_index  out  6  command index
cmd_arg  out  32  command argument
cmd_rsp_type  out  2  0 none, 1 short (48-bit), 2 long (136-bit)
cmd_chk_crc  out  1  engine must check response CRC7
rsp_valid  in  1  one-cycle pulse; response complete (or sent, for type 0)
rsp_timeout  in  1  qualifies rsp_valid; no start bit seen
rsp_crc_err  in  1  qualifies rsp_valid; CRC7 mismatch
rsp_data  in  32  response bits [39:8] of a short response
ocr  out  32  last ACMD41 payload
ccs  out  1  card capacity status (ocr[30])
rca  out  16  relative card address from CMD3
v2_card  out  1  CMD8 answered with a correct echo

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. rst mid-transaction drops cmd_valid in the same cycle; any later rsp_valid is ignored.
- Handshake: cmd_valid is held with index/arg/type stable until the cycle where cmd_valid&cmd_ready; it drops the next cycle. One outstanding command. rsp_valid is used only in WAIT_* states and ignored elsewhere.
- States:
  - IDLE: wait for start.
  - POWERUP: count POWERUP_WAIT cycles.
  - CMD0: idx 0, arg 0, type 0, no CRC check. Any rsp_valid advances.
  - CMD8: idx 8, arg 0x000001AA, type 1.
    - Timeout: v2_card=0, continue.
    - rsp_data[11:0]==0x1AA and no CRC error: v2_card=1.
    - Otherwise: error code 1.
  - CMD55: idx 55, arg 0, type 1. Timeout gives code 3; CRC error gives code 4.
  - ACMD41: idx 41, arg = {1'b0, HCS&v2_card, 6'b0, 24'hFF8000}, type 1, cmd_chk_crc=0 (R3 carries no valid CRC).
    - Timeout: code 3.
    - Otherwise latch ocr=rsp_data.
    - If rsp_data[31]=1: latch ccs and go to CMD2.
    - Else increment the retry counter. When the count reaches ACMD41_RETRIES, code 2; else go back to CMD55.
  - CMD2: idx 2, arg 0, type 2, CRC check. The CID is discarded. Timeout gives code 3; CRC error gives code 4.
  - CMD3: idx 3, arg 0, type 1. On success latch rca=rsp_data[31:16] and go to DONE. Timeout gives code 3; CRC error gives code 4.
  - DONE / ERROR: outputs held; start restarts from POWERUP and clears done, error, err_code, ocr, rca, v2_card and the retry counter.
- Start handling: start while busy is ignored.
- Simultaneous flags: if rsp_timeout and rsp_crc_err are both set, timeout wins.
- Latency: start to first cmd_valid = POWERUP_WAIT+1 cycles. rsp_valid to the next cmd_valid = 1 cycle.
- busy = not (IDLE, DONE, ERROR).

Optional Feature:
SDINIT_CMD7_SELECT_EN:
- Defined: after CMD3, issue CMD7 with arg {rca,16'h0000}, type 1, CRC check, then DONE. Timeout gives code 3; CRC error gives code 4.
- Undefined: CMD3 success goes directly to DONE and CMD7 is never issued.

Test Plan:
1. Nominal v2: start; CMD8 echo 0x1AA; ACMD41 returns 0x00FF8000 twice then 0xC0FF8000; CMD3 rsp_data 0xB3680500 -> commands issued in order 0, 8, 55, 41, 55, 41, 55, 41, 2, 3; ACMD41 arg 0x40FF8000; done=1, ccs=1, rca=0xB368, v2_card=1.
2. v1 card: CMD8 rsp_timeout -> v2_card=0, ACMD41 arg 0x00FF8000, sequence completes.
3. Bad echo: CMD8 rsp_data=0x000001AB -> error=1, err_code=1, cmd_valid stays 0.
4. Retry exhaustion: ACMD41_RETRIES=3, busy bit never set -> exactly 3 ACMD41 issued, err_code=2.
5. Backpressure and reset: hold cmd_ready=0 for 20 cycles on CMD55 -> cmd_valid and fields stable. Assert rst mid-wait -> next cycle cmd_valid=0, busy=0; a stale rsp_valid then causes no state change.
6. CRC handling: crc_err on ACMD41 is ignored, and crc_err on CMD2 gives err_code=4. With SDINIT_CMD7_SELECT_EN defined, CMD7 arg=0xB3680000.

Source files
------------

// File: rtl/sd_init_sequencer_if.sv
// Command/response channel between the SD init sequencer (master) and the
// CMD-line shifter engine (slave).
interface sd_init_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  cmd_rsp_type;
    logic        cmd_chk_crc;
    logic        rsp_valid;
    logic        rsp_timeout;
    logic        rsp_crc_err;
    logic [31:0] rsp_data;

    modport master (
        output cmd_valid, cmd_index, cmd_arg, cmd_rsp_type, cmd_chk_crc,
        input  cmd_ready, rsp_valid, rsp_timeout, rsp_crc_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_arg, cmd_rsp_type, cmd_chk_crc,
        output cmd_ready, rsp_valid, rsp_timeout, rsp_crc_err, rsp_data
    );
endinterface

// File: rtl/sd_init_sequencer.sv
// SD card identification sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3.
// Define SDINIT_CMD7_SELECT_EN to append a CMD7 card-select step before DONE.
module sd_init_sequencer #(
    parameter int POWERUP_WAIT   = 27000,
    parameter int ACMD41_RETRIES = 1000,
    parameter bit HCS            = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [3:0]                 err_code_o,
    output logic [31:0]                ocr_o,
    output logic                       ccs_o,
    output logic [15:0]                rca_o,
    output logic                       v2_card_o,
    sd_init_sequencer_if.master        cmd_if
);

    localparam int              PW_W      = (POWERUP_WAIT > 1) ? $clog2(POWERUP_WAIT) : 1;
    localparam logic [PW_W-1:0] PW_LAST   = PW_W'(POWERUP_WAIT - 1);
    localparam logic [9:0]      RETRY_MAX = 10'(ACMD41_RETRIES);

    localparam logic [3:0] ERR_ECHO    = 4'd1;
    localparam logic [3:0] ERR_RETRY   = 4'd2;
    localparam logic [3:0] ERR_TIMEOUT = 4'd3;
    localparam logic [3:0] ERR_CRC     = 4'd4;

    // Each WAIT state encodes as its issue state + 1.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'd0,  ST_POWERUP = 5'd1,
        ST_CMD0    = 5'd2,  ST_WAIT0   = 5'd3,
        ST_CMD8    = 5'd4,  ST_WAIT8   = 5'd5,
        ST_CMD55   = 5'd6,  ST_WAIT55  = 5'd7,
        ST_ACMD41  = 5'd8,  ST_WAIT41  = 5'd9,
        ST_CMD2    = 5'd10, ST_WAIT2   = 5'd11,
        ST_CMD3    = 5'd12, ST_WAIT3   = 5'd13,
        ST_CMD7    = 5'd14, ST_WAIT7   = 5'd15,
        ST_DONE    = 5'd16, ST_ERROR   = 5'd17
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [5:0]  index;
        logic [31:0] arg;
        logic [1:0]  rsp_type;
        logic        chk_crc;
    } cmd_t;

    function automatic cmd_t cmd_for(input state_e st, input logic v2, input logic [15:0] rca);
        cmd_t c;
        c = '0;
        case (st)
            ST_CMD0:   c = '{1'b1, 6'd0,  32'h0000_0000, 2'd0, 1'b0};
            ST_CMD8:   c = '{1'b1, 6'd8,  32'h0000_01AA, 2'd1, 1'b1};
            ST_CMD55:  c = '{1'b1, 6'd55, 32'h0000_0000, 2'd1, 1'b1};
            ST_ACMD41: c = '{1'b1, 6'd41, {1'b0, HCS & v2, 6'b000000, 24'hFF8000}, 2'd1, 1'b0};
            ST_CMD2:   c = '{1'b1, 6'd2,  32'h0000_0000, 2'd2, 1'b1};
            ST_CMD3:   c = '{1'b1, 6'd3,  32'h0000_0000, 2'd1, 1'b1};
            ST_CMD7:   c = '{1'b1, 6'd7,  {rca, 16'h0000}, 2'd1, 1'b1};
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_e          state_q, state_d;
    logic [PW_W-1:0] pw_cnt_q, pw_cnt_d;
    logic [9:0]      retry_q, retry_d;
    logic [3:0]      err_code_q, err_code_d;
    logic [31:0]     ocr_q, ocr_d;
    logic            ccs_q, ccs_d;
    logic [15:0]     rca_q, rca_d;
    logic            v2_q, v2_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    cmd_t            cmd_q, cmd_d;

    logic            rsp_s;
    logic            rsp_to_s;
    logic            rsp_crc_s;
    logic [31:0]     rsp_data_s;

    assign rsp_s      = cmd_if.rsp_valid;
    assign rsp_to_s   = cmd_if.rsp_timeout;
    assign rsp_crc_s  = cmd_if.rsp_crc_err;
    assign rsp_data_s = cmd_if.rsp_data;

    // Next-state and next-output logic for the init flow.
    always_comb begin
        state_d    = state_q;
        pw_cnt_d   = pw_cnt_q;
        retry_d    = retry_q;
        err_code_d = err_code_q;
        ocr_d      = ocr_q;
        ccs_d      = ccs_q;
        rca_d      = rca_q;
        v2_d       = v2_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d    = ST_POWERUP;
                    pw_cnt_d   = '0;
                    retry_d    = 10'd0;
                    err_code_d = 4'd0;
                    ocr_d      = 32'h0000_0000;
                    ccs_d      = 1'b0;
                    rca_d      = 16'h0000;
                    v2_d       = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_POWERUP: begin
                if (pw_cnt_q == PW_LAST) begin
                    state_d = ST_CMD0;
                end else begin
                    pw_cnt_d = pw_cnt_q + {{(PW_W-1){1'b0}}, 1'b1};
                end
            end
            ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD2, ST_CMD3, ST_CMD7: begin
                if (cmd_q.valid && cmd_if.cmd_ready) begin
                    state_d = state_e'(state_q + 5'd1);
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT0: begin
                if (rsp_s) begin
                    state_d = ST_CMD8;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT8: begin
                if (!rsp_s) begin
                    state_d = state_q;
                end else if (rsp_to_s) begin
                    v2_d    = 1'b0;
                    state_d = ST_CMD55;
                end else if (!rsp_crc_s && rsp_data_s[11:0] == 12'h1AA) begin
                    v2_d    = 1'b1;
                    state_d = ST_CMD55;
                end else begin
                    err_code_d = ERR_ECHO;
                    state_d    = ST_ERROR;
                end
            end
            // R3 has no meaningful CRC, so only a timeout aborts here.
            ST_WAIT41: begin
                if (!rsp_s) begin
                    state_d = state_q;
                end else if (rsp_to_s) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERROR;
                end else begin
                    ocr_d = rsp_data_s;
                    if (rsp_data_s[31]) begin
                        ccs_d   = rsp_data_s[30];
                        state_d = ST_CMD2;
                    end else begin
                        retry_d = retry_q + 10'd1;
                        if ((retry_q + 10'd1) == RETRY_MAX) begin
                            err_code_d = ERR_RETRY;
                            state_d    = ST_ERROR;
                        end else begin
                            state_d = ST_CMD55;
                        end
                    end
                end
            end
            ST_WAIT55, ST_WAIT2, ST_WAIT3, ST_WAIT7: begin
                if (!rsp_s) begin
                    state_d = state_q;
                end else if (rsp_to_s) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERROR;
                end else if (rsp_crc_s) begin
                    err_code_d = ERR_CRC;
                    state_d    = ST_ERROR;
                end else if (state_q == ST_WAIT55) begin
                    state_d = ST_ACMD41;
                end else if (state_q == ST_WAIT2) begin
                    state_d = ST_CMD3;
                end else if (state_q == ST_WAIT3) begin
                    rca_d = rsp_data_s[31:16];
`ifdef SDINIT_CMD7_SELECT_EN
                    state_d = ST_CMD7;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_d   = cmd_for(state_d, v2_d, rca_d);
        busy_d  = !(state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERROR);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    // State register and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pw_cnt_q   <= '0;
            retry_q    <= 10'd0;
            err_code_q <= 4'd0;
            ocr_q      <= 32'h0000_0000;
            ccs_q      <= 1'b0;
            rca_q      <= 16'h0000;
            v2_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cmd_q      <= '0;
        end else begin
            state_q    <= state_d;
            pw_cnt_q   <= pw_cnt_d;
            retry_q    <= retry_d;
            err_code_q <= err_code_d;
            ocr_q      <= ocr_d;
            ccs_q      <= ccs_d;
            rca_q      <= rca_d;
            v2_q       <= v2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cmd_q      <= cmd_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign err_code_o   = err_code_q;
    assign ocr_o        = ocr_q;
    assign ccs_o        = ccs_q;
    assign rca_o        = rca_q;
    assign v2_card_o    = v2_q;

    assign cmd_if.cmd_valid    = cmd_q.valid;
    assign cmd_if.cmd_index    = cmd_q.index;
    assign cmd_if.cmd_arg      = cmd_q.arg;
    assign cmd_if.cmd_rsp_type = cmd_q.rsp_type;
    assign cmd_if.cmd_chk_crc  = cmd_q.chk_crc;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer; the bench plays the CMD engine.
module tb_sd_init_sequencer;
    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, error, ccs, v2;
    logic [3:0]  err_code;
    logic [31:0] ocr;
    logic [15:0] rca;
    int          n_cmp = 0;
    int          n_err = 0;

    sd_init_sequencer_if bus();

    sd_init_sequencer #(
        .POWERUP_WAIT   (PW),
        .ACMD41_RETRIES (3),
        .HCS            (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .err_code_o (err_code),
        .ocr_o      (ocr),
        .ccs_o      (ccs),
        .rca_o      (rca),
        .v2_card_o  (v2),
        .cmd_if     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic b, input logic d, input logic e,
                                input logic [3:0] code);
        check({tag, " status"}, 64'({busy, done, error, err_code}), 64'({b, d, e, code}));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cmd(input string tag, input int exp_lat);
        int lat = 0;
        while (bus.cmd_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " valid"}, 64'(bus.cmd_valid), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_fields(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                                input logic [1:0] typ, input logic chk);
        check({tag, " fields"},
              64'({bus.cmd_index, bus.cmd_arg, bus.cmd_rsp_type, bus.cmd_chk_crc}),
              64'({idx, arg, typ, chk}));
    endtask

    task automatic accept(input string tag);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        check({tag, " dropped"}, 64'(bus.cmd_valid), 64'd0);
    endtask

    task automatic expect_cmd(input string tag, input int lat, input logic [5:0] idx,
                              input logic [31:0] arg, input logic [1:0] typ, input logic chk);
        wait_cmd(tag, lat);
        check_fields(tag, idx, arg, typ, chk);
        accept(tag);
    endtask

    task automatic respond(input logic to, input logic crc, input logic [31:0] data);
        bus.rsp_valid   = 1'b1;
        bus.rsp_timeout = to;
        bus.rsp_crc_err = crc;
        bus.rsp_data    = data;
        @(negedge clk);
        bus.rsp_valid   = 1'b0;
        bus.rsp_timeout = 1'b0;
        bus.rsp_crc_err = 1'b0;
        bus.rsp_data    = 32'h0000_0000;
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check({tag, " no cmd"}, 64'(bus.cmd_valid), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.cmd_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_timeout = 1'b0;
        bus.rsp_crc_err = 1'b0;
        bus.rsp_data    = 32'h0000_0000;
        repeat (3) @(negedge clk);

        // Reset state
        check_status("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        check("reset cmd_valid", 64'(bus.cmd_valid), 64'd0);
        check("reset regs", 64'({ocr, rca, ccs, v2}), 64'd0);
        check_fields("reset", 6'd0, 32'h0, 2'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal v2 card, with a CRC error on the first ACMD41 ignored
        pulse_start();
        check_status("t1 start", 1'b1, 1'b0, 1'b0, 4'd0);
        expect_cmd("t1 cmd0", PW, 6'd0, 32'h0, 2'd0, 1'b0);
        pulse_start();
        respond(1'b0, 1'b0, 32'h0);
        expect_cmd("t1 cmd8", 0, 6'd8, 32'h0000_01AA, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0000_01AA);
        check("t1 v2", 64'(v2), 64'd1);
        for (int i = 0; i < 3; i++) begin
            expect_cmd("t1 cmd55", 0, 6'd55, 32'h0, 2'd1, 1'b1);
            respond(1'b0, 1'b0, 32'h0000_0120);
            expect_cmd("t1 acmd41", 0, 6'd41, 32'h40FF_8000, 2'd1, 1'b0);
            respond(1'b0, (i == 0), (i == 2) ? 32'hC0FF_8000 : 32'h00FF_8000);
        end
        expect_cmd("t1 cmd2", 0, 6'd2, 32'h0, 2'd2, 1'b1);
        respond(1'b0, 1'b0, 32'h1234_5678);
        expect_cmd("t1 cmd3", 0, 6'd3, 32'h0, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'hB368_0500);
`ifdef SDINIT_CMD7_SELECT_EN
        expect_cmd("t1 cmd7", 0, 6'd7, 32'hB368_0000, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0000_0700);
`endif
        check_status("t1 done", 1'b0, 1'b1, 1'b0, 4'd0);
        check("t1 ocr", 64'(ocr), 64'hC0FF_8000);
        check("t1 ccs/v2/rca", 64'({ccs, v2, rca}), 64'({1'b1, 1'b1, 16'hB368}));
        idle_check("t1 after", 2);

        // Retry exhaustion; retry counter left at 2 above must be cleared
        pulse_start();
        check_status("t4 start", 1'b1, 1'b0, 1'b0, 4'd0);
        check("t4 cleared", 64'({ocr, rca, ccs, v2}), 64'd0);
        expect_cmd("t4 cmd0", PW, 6'd0, 32'h0, 2'd0, 1'b0);
        respond(1'b0, 1'b0, 32'h0);
        expect_cmd("t4 cmd8", 0, 6'd8, 32'h0000_01AA, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0000_01AA);
        for (int i = 0; i < 3; i++) begin
            expect_cmd("t4 cmd55", 0, 6'd55, 32'h0, 2'd1, 1'b1);
            respond(1'b0, 1'b0, 32'h0000_0120);
            expect_cmd("t4 acmd41", 0, 6'd41, 32'h40FF_8000, 2'd1, 1'b0);
            respond(1'b0, 1'b0, 32'h00FF_8000);
        end
        check_status("t4 err", 1'b0, 1'b0, 1'b1, 4'd2);
        check("t4 ocr", 64'(ocr), 64'h00FF_8000);
        idle_check("t4 after", 5);

        // v1 card: CMD8 timeout (with simultaneous CRC flag, timeout wins)
        pulse_start();
        check_status("t2 start", 1'b1, 1'b0, 1'b0, 4'd0);
        expect_cmd("t2 cmd0", PW, 6'd0, 32'h0, 2'd0, 1'b0);
        respond(1'b0, 1'b0, 32'h0);
        expect_cmd("t2 cmd8", 0, 6'd8, 32'h0000_01AA, 2'd1, 1'b1);
        respond(1'b1, 1'b1, 32'h0000_01AA);
        check("t2 v2", 64'(v2), 64'd0);
        expect_cmd("t2 cmd55", 0, 6'd55, 32'h0, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0000_0120);
        expect_cmd("t2 acmd41", 0, 6'd41, 32'h00FF_8000, 2'd1, 1'b0);
        respond(1'b0, 1'b0, 32'h80FF_8000);
        expect_cmd("t2 cmd2", 0, 6'd2, 32'h0, 2'd2, 1'b1);
        respond(1'b0, 1'b0, 32'h0);
        expect_cmd("t2 cmd3", 0, 6'd3, 32'h0, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h1234_0000);
`ifdef SDINIT_CMD7_SELECT_EN
        expect_cmd("t2 cmd7", 0, 6'd7, 32'h1234_0000, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0);
`endif
        check_status("t2 done", 1'b0, 1'b1, 1'b0, 4'd0);
        check("t2 ccs/v2/rca", 64'({ccs, v2, rca}), 64'({1'b0, 1'b0, 16'h1234}));
        check("t2 ocr", 64'(ocr), 64'h80FF_8000);

        // Bad CMD8 echo
        pulse_start();
        expect_cmd("t3 cmd0", PW, 6'd0, 32'h0, 2'd0, 1'b0);
        respond(1'b0, 1'b0, 32'h0);
        expect_cmd("t3 cmd8", 0, 6'd8, 32'h0000_01AA, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0000_01AB);
        check_status("t3 err", 1'b0, 1'b0, 1'b1, 4'd1);
        idle_check("t3 after", 5);

        // Backpressure on CMD55, stray response while issuing, then reset
        pulse_start();
        expect_cmd("t5 cmd0", PW, 6'd0, 32'h0, 2'd0, 1'b0);
        respond(1'b0, 1'b0, 32'h0);
        expect_cmd("t5 cmd8", 0, 6'd8, 32'h0000_01AA, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0000_01AA);
        wait_cmd("t5 cmd55", 0);
        for (int i = 0; i < 10; i++) begin
            check_fields("t5 hold", 6'd55, 32'h0, 2'd1, 1'b1);
            check("t5 hold valid", 64'(bus.cmd_valid), 64'd1);
            @(negedge clk);
        end
        respond(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            check_fields("t5 hold2", 6'd55, 32'h0, 2'd1, 1'b1);
            check("t5 hold2 valid", 64'(bus.cmd_valid), 64'd1);
            @(negedge clk);
        end
        check_status("t5 busy", 1'b1, 1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t5 rst valid", 64'(bus.cmd_valid), 64'd0);
        check_status("t5 rst", 1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        respond(1'b0, 1'b0, 32'h0000_01AA);
        check_status("t5 stale", 1'b0, 1'b0, 1'b0, 4'd0);
        idle_check("t5 after", 3);
        check_status("t5 idle", 1'b0, 1'b0, 1'b0, 4'd0);

        // CRC error on CMD2
        pulse_start();
        expect_cmd("t6 cmd0", PW, 6'd0, 32'h0, 2'd0, 1'b0);
        respond(1'b0, 1'b0, 32'h0);
        expect_cmd("t6 cmd8", 0, 6'd8, 32'h0000_01AA, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0000_01AA);
        expect_cmd("t6 cmd55", 0, 6'd55, 32'h0, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0000_0120);
        expect_cmd("t6 acmd41", 0, 6'd41, 32'h40FF_8000, 2'd1, 1'b0);
        respond(1'b0, 1'b0, 32'hC0FF_8000);
        expect_cmd("t6 cmd2", 0, 6'd2, 32'h0, 2'd2, 1'b1);
        respond(1'b0, 1'b1, 32'h0);
        check_status("t6 crc", 1'b0, 1'b0, 1'b1, 4'd4);

        // Timeout on CMD55
        pulse_start();
        expect_cmd("t7 cmd0", PW, 6'd0, 32'h0, 2'd0, 1'b0);
        respond(1'b0, 1'b0, 32'h0);
        expect_cmd("t7 cmd8", 0, 6'd8, 32'h0000_01AA, 2'd1, 1'b1);
        respond(1'b0, 1'b0, 32'h0000_01AA);
        expect_cmd("t7 cmd55", 0, 6'd55, 32'h0, 2'd1, 1'b1);
        respond(1'b1, 1'b1, 32'h0);
        check_status("t7 timeout", 1'b0, 1'b0, 1'b1, 4'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
